// File: rtl/csr_snapshot_streamer_if.sv
// csr_snapshot_streamer_if
// Beat stream from the CSR snapshot streamer to the trace sink.
//   out_valid : beat available (master -> slave)
//   out_ready : sink accepts the beat (slave -> master)
//   out_data  : 64-bit field value of the current beat
//   out_idx   : field index 0..28 within the frame
//   out_last  : high on the final beat (index 28)
//   out_seq   : frame sequence number of the current beat
`timescale 1ns/1ps

interface csr_snapshot_streamer_if #(
    parameter int SEQ_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [4:0]       out_idx;
    logic             out_last;
    logic [SEQ_W-1:0] out_seq;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_seq,
        output out_ready
    );
endinterface

// File: rtl/csr_snapshot_streamer.sv
// csr_snapshot_streamer
// Captures a full CSR pack on each commit strobe and streams it out as a
// frame of 29 64-bit beats. One frame is in flight (active slot) and one
// more can wait (pending slot); commits arriving while both are occupied
// are dropped and counted.
//   clk          : rising-edge clock
//   rstn         : asynchronous active-low reset
//   commit_valid : capture csr_in this cycle
//   csr_in       : CSR snapshot to capture
//   stream       : beat stream (valid/ready, data, idx, last, seq)
//   busy         : an active frame is in flight (same as out_valid)
//   drop_cnt     : saturating count of dropped snapshots
`timescale 1ns/1ps

package CSRStruct;
    // Field order matches the beat order of a frame.
    typedef struct packed {
        logic [63:0] sstatus;
        logic [63:0] sie;
        logic [63:0] stvec;
        logic [63:0] sscratch;
        logic [63:0] sepc;
        logic [63:0] scause;
        logic [63:0] stval;
        logic [63:0] sip;
        logic [63:0] satp;
        logic [63:0] mstatus;
        logic [63:0] mie;
        logic [63:0] mtvec;
        logic [63:0] mcounteren;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mip;
        logic [63:0] medeleg;
        logic [63:0] mideleg;
        logic [63:0] mcycle;
        logic [63:0] minstret;
        logic [63:0] priv;
        logic [63:0] switch_mode;
        logic [63:0] pc_csr;
        logic [63:0] cosim_epc;
        logic [63:0] cosim_cause;
        logic [63:0] cosim_tval;
        logic [63:0] csr_ret;
    } CSRPack;
endpackage

module csr_snapshot_streamer #(
    parameter int DROP_W = 16,
    parameter int SEQ_W  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    commit_valid,
    input  CSRStruct::CSRPack       csr_in,
    csr_snapshot_streamer_if.master stream,
    output logic                    busy,
    output logic [DROP_W-1:0]       drop_cnt
);

    localparam logic [4:0] LAST_IDX = 5'd28;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [4:0]        idx_q;
    CSRStruct::CSRPack active_q;
    CSRStruct::CSRPack pending_q;
    logic [SEQ_W-1:0]  activeSeq_q;
    logic [SEQ_W-1:0]  pendingSeq_q;
    logic              pendingValid_q;
    logic [SEQ_W-1:0]  seqCnt_q;
    logic [DROP_W-1:0] dropCnt_q;

    logic              handshake;
    logic              finalBeat;
    logic [SEQ_W-1:0]  seqNext_d;
    logic [63:0]       beatData_d;

    assign handshake = (state_q == SEND) && stream.out_ready;
    assign finalBeat = handshake && (idx_q == LAST_IDX);
    assign seqNext_d = seqCnt_q + SEQ_W'(1);

    // Frame sequencing, slot management and drop accounting. A commit only
    // consumes a sequence number when it lands in a slot; drops leave it alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            activeSeq_q    <= '0;
            pendingSeq_q   <= '0;
            pendingValid_q <= 1'b0;
            seqCnt_q       <= '0;
            dropCnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (commit_valid) begin
                        active_q    <= csr_in;
                        activeSeq_q <= seqCnt_q;
                        seqCnt_q    <= seqNext_d;
                        idx_q       <= '0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (finalBeat) begin
                        // Frame boundary: promote the next frame with no idle beat.
                        if (pendingValid_q) begin
                            active_q    <= pending_q;
                            activeSeq_q <= pendingSeq_q;
                            idx_q       <= '0;
                            if (commit_valid) begin
                                pending_q    <= csr_in;
                                pendingSeq_q <= seqCnt_q;
                                seqCnt_q     <= seqNext_d;
                            end else begin
                                pendingValid_q <= 1'b0;
                            end
                        end else if (commit_valid) begin
                            active_q    <= csr_in;
                            activeSeq_q <= seqCnt_q;
                            seqCnt_q    <= seqNext_d;
                            idx_q       <= '0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            idx_q <= idx_q + 5'd1;
                        end
                        if (commit_valid) begin
                            if (!pendingValid_q) begin
                                pending_q      <= csr_in;
                                pendingSeq_q   <= seqCnt_q;
                                pendingValid_q <= 1'b1;
                                seqCnt_q       <= seqNext_d;
                            end else if (dropCnt_q != {DROP_W{1'b1}}) begin
                                dropCnt_q <= dropCnt_q + DROP_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Field select for the current beat, driven only by registered state so
    // the beat holds steady while the sink stalls.
    always_comb begin
        beatData_d = '0;
        case (idx_q)
            5'd0:  beatData_d = active_q.sstatus;
            5'd1:  beatData_d = active_q.sie;
            5'd2:  beatData_d = active_q.stvec;
            5'd3:  beatData_d = active_q.sscratch;
            5'd4:  beatData_d = active_q.sepc;
            5'd5:  beatData_d = active_q.scause;
            5'd6:  beatData_d = active_q.stval;
            5'd7:  beatData_d = active_q.sip;
            5'd8:  beatData_d = active_q.satp;
            5'd9:  beatData_d = active_q.mstatus;
            5'd10: beatData_d = active_q.mie;
            5'd11: beatData_d = active_q.mtvec;
            5'd12: beatData_d = active_q.mcounteren;
            5'd13: beatData_d = active_q.mscratch;
            5'd14: beatData_d = active_q.mepc;
            5'd15: beatData_d = active_q.mcause;
            5'd16: beatData_d = active_q.mtval;
            5'd17: beatData_d = active_q.mip;
            5'd18: beatData_d = active_q.medeleg;
            5'd19: beatData_d = active_q.mideleg;
            5'd20: beatData_d = active_q.mcycle;
            5'd21: beatData_d = active_q.minstret;
            5'd22: beatData_d = active_q.priv;
            5'd23: beatData_d = active_q.switch_mode;
            5'd24: beatData_d = active_q.pc_csr;
            5'd25: beatData_d = active_q.cosim_epc;
            5'd26: beatData_d = active_q.cosim_cause;
            5'd27: beatData_d = active_q.cosim_tval;
            5'd28: beatData_d = active_q.csr_ret;
            default: beatData_d = '0;
        endcase
    end

    // Data is forced to zero while idle so an idle bus looks like reset.
    assign stream.out_valid = (state_q == SEND);
    assign stream.out_data  = (state_q == SEND) ? beatData_d : 64'd0;
    assign stream.out_idx   = idx_q;
    assign stream.out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign stream.out_seq   = activeSeq_q;
    assign busy             = (state_q == SEND);
    assign drop_cnt         = dropCnt_q;

endmodule

// File: tb/tb_csr_snapshot_streamer.sv
// tb_csr_snapshot_streamer
// Scoreboard bench for csr_snapshot_streamer. Stimulus pushes the expected
// beats of every frame that should be streamed; a negedge monitor pops and
// compares each accepted beat and checks that stalled beats hold steady.
`timescale 1ns/1ps

module tb_csr_snapshot_streamer;
   import CSRStruct::*;

   localparam int SEQ_W  = 16;
   localparam int DROP_W = 16;

   typedef struct {
      logic [SEQ_W-1:0] seq;
      logic [4:0]       idx;
      logic [63:0]      data;
      logic             last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              commitValid = 1'b0;
   CSRPack            csrIn = '0;
   logic              busy;
   logic [DROP_W-1:0] dropCnt;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
   logic  stalled = 1'b0;
   beat_t saved;
   beat_t expBeat;

   csr_snapshot_streamer_if #(.SEQ_W(SEQ_W)) dutIf ();

   csr_snapshot_streamer #(
      .DROP_W(DROP_W),
      .SEQ_W (SEQ_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .commit_valid(commitValid),
      .csr_in      (csrIn),
      .stream      (dutIf.master),
      .busy        (busy),
      .drop_cnt    (dropCnt)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Field i of the pack carries base+i; field 0 sits in the MSBs.
   function automatic CSRPack makePack(input logic [63:0] base);
      logic [28:0][63:0] flat;
      for (int i = 0; i < 29; i++) flat[28-i] = base + 64'(i);
      return CSRPack'(flat);
   endfunction

   task automatic pushFrame(input logic [SEQ_W-1:0] seq, input logic [63:0] base);
      for (int i = 0; i < 29; i++) begin
         sb.push_back('{seq: seq, idx: 5'(i), data: base + 64'(i), last: (i == 28)});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input CSRPack pack);
      commitValid = valid;
      csrIn       = pack;
   endtask

   task automatic waitBeat(input string name, input logic [4:0] idx, input logic [SEQ_W-1:0] seq, input int maxCycles);
      int n = 0;
      while (!(dutIf.out_valid && dutIf.out_idx == idx && dutIf.out_seq == seq) && n < maxCycles) begin
         step();
         n++;
      end
      checkOutput(name, 64'(n < maxCycles), 64'd1);
   endtask

   task automatic drain(input string name, input int maxCycles);
      int n = 0;
      while ((sb.size() != 0 || dutIf.out_valid) && n < maxCycles) begin
         step();
         n++;
      end
      checkOutput(name, 64'(n < maxCycles), 64'd1);
      checkOutput("sbEmpty", 64'(sb.size()), 64'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "Valid"}, 64'(dutIf.out_valid), 64'd0);
      checkOutput({tag, "Data"},  dutIf.out_data,       64'd0);
      checkOutput({tag, "Idx"},   64'(dutIf.out_idx),   64'd0);
      checkOutput({tag, "Last"},  64'(dutIf.out_last),  64'd0);
      checkOutput({tag, "Seq"},   64'(dutIf.out_seq),   64'd0);
      checkOutput({tag, "Busy"},  64'(busy),            64'd0);
      checkOutput({tag, "Drop"},  64'(dropCnt),         64'd0);
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard, and
   // a beat that was stalled must look identical on the following cycle.
   always @(negedge clk) begin
      if (!rstn) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            checkOutput("stableData", dutIf.out_data,       saved.data);
            checkOutput("stableIdx",  64'(dutIf.out_idx),   64'(saved.idx));
            checkOutput("stableLast", 64'(dutIf.out_last),  64'(saved.last));
            checkOutput("stableSeq",  64'(dutIf.out_seq),   64'(saved.seq));
         end
         if (dutIf.out_valid && dutIf.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedBeat actual idx=%0d seq=%0d required no beat", dutIf.out_idx, dutIf.out_seq);
            end else begin
               expBeat = sb.pop_front();
               checkOutput("beatData", dutIf.out_data,      expBeat.data);
               checkOutput("beatIdx",  64'(dutIf.out_idx),  64'(expBeat.idx));
               checkOutput("beatLast", 64'(dutIf.out_last), 64'(expBeat.last));
               checkOutput("beatSeq",  64'(dutIf.out_seq),  64'(expBeat.seq));
            end
         end
         stalled    = dutIf.out_valid && !dutIf.out_ready;
         saved.data = dutIf.out_data;
         saved.idx  = dutIf.out_idx;
         saved.last = dutIf.out_last;
         saved.seq  = dutIf.out_seq;
      end
   end

   // Watchdog so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios: single frame, backpressure, pending chain,
   // overflow, commit on the final handshake, and reset mid-frame.
   initial begin
      dutIf.out_ready = 1'b1;
      rstn            = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rstn = 1'b1;
      step();
      step();

      // Single frame with the sink always ready.
      applyStimulus(1'b1, makePack(64'h1000));
      pushFrame(16'd0, 64'h1000);
      step();
      applyStimulus(1'b0, '0);
      @(negedge clk);
      checkOutput("t1FirstValid", 64'(dutIf.out_valid), 64'd1);
      checkOutput("t1FirstIdx",   64'(dutIf.out_idx),   64'd0);
      checkOutput("t1FirstLast",  64'(dutIf.out_last),  64'd0);
      checkOutput("t1FirstBusy",  64'(busy),            64'd1);
      repeat (28) @(negedge clk);
      checkOutput("t1LastIdx",  64'(dutIf.out_idx),  64'd28);
      checkOutput("t1LastFlag", 64'(dutIf.out_last), 64'd1);
      @(negedge clk);
      checkOutput("t1IdleValid", 64'(dutIf.out_valid), 64'd0);
      checkOutput("t1IdleBusy",  64'(busy),            64'd0);
      drain("t1Drain", 100);

      // Random backpressure while a frame streams.
      step();
      applyStimulus(1'b1, makePack(64'h2000));
      pushFrame(16'd1, 64'h2000);
      dutIf.out_ready = 1'b0;
      step();
      applyStimulus(1'b0, '0);
      begin
         int n = 0;
         while (sb.size() != 0 && n < 400) begin
            dutIf.out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
         end
         checkOutput("t2Progress", 64'(n < 400), 64'd1);
      end
      dutIf.out_ready = 1'b1;
      drain("t2Drain", 100);

      // Pending chain: B committed three cycles after A.
      step();
      applyStimulus(1'b1, makePack(64'h3000));
      pushFrame(16'd2, 64'h3000);
      step();
      applyStimulus(1'b0, '0);
      step();
      step();
      applyStimulus(1'b1, makePack(64'h4000));
      pushFrame(16'd3, 64'h4000);
      step();
      applyStimulus(1'b0, '0);
      waitBeat("t3WaitALast", 5'd28, 16'd2, 60);
      step();
      checkOutput("t3BValid", 64'(dutIf.out_valid), 64'd1);
      checkOutput("t3BIdx",   64'(dutIf.out_idx),   64'd0);
      checkOutput("t3BSeq",   64'(dutIf.out_seq),   64'd3);
      drain("t3Drain", 100);

      // Overflow: four back-to-back commits with the sink stalled.
      dutIf.out_ready = 1'b0;
      step();
      applyStimulus(1'b1, makePack(64'h5000));
      pushFrame(16'd4, 64'h5000);
      step();
      applyStimulus(1'b1, makePack(64'h6000));
      pushFrame(16'd5, 64'h6000);
      step();
      applyStimulus(1'b1, makePack(64'h7000));
      step();
      applyStimulus(1'b1, makePack(64'h7100));
      step();
      applyStimulus(1'b0, '0);
      @(negedge clk);
      checkOutput("t4Drop",  64'(dropCnt),          64'd2);
      checkOutput("t4Idx",   64'(dutIf.out_idx),    64'd0);
      checkOutput("t4Seq",   64'(dutIf.out_seq),    64'd4);
      checkOutput("t4Valid", 64'(dutIf.out_valid),  64'd1);
      step();
      step();
      dutIf.out_ready = 1'b1;
      drain("t4Drain", 200);
      step();
      applyStimulus(1'b1, makePack(64'h7200));
      pushFrame(16'd6, 64'h7200);
      step();
      applyStimulus(1'b0, '0);
      @(negedge clk);
      checkOutput("t4NextSeq", 64'(dutIf.out_seq), 64'd6);
      drain("t4Drain2", 100);

      // Commit on the final handshake, first with pending full, then empty.
      step();
      applyStimulus(1'b1, makePack(64'h8000));
      pushFrame(16'd7, 64'h8000);
      step();
      applyStimulus(1'b1, makePack(64'h9000));
      pushFrame(16'd8, 64'h9000);
      step();
      applyStimulus(1'b0, '0);
      waitBeat("t5WaitALast", 5'd28, 16'd7, 60);
      applyStimulus(1'b1, makePack(64'hA000));
      pushFrame(16'd9, 64'hA000);
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t5BValid", 64'(dutIf.out_valid), 64'd1);
      checkOutput("t5BIdx",   64'(dutIf.out_idx),   64'd0);
      checkOutput("t5BSeq",   64'(dutIf.out_seq),   64'd8);
      checkOutput("t5Drop",   64'(dropCnt),         64'd2);
      waitBeat("t5WaitCLast", 5'd28, 16'd9, 100);
      applyStimulus(1'b1, makePack(64'hB000));
      pushFrame(16'd10, 64'hB000);
      step();
      applyStimulus(1'b0, '0);
      checkOutput("t5DValid", 64'(dutIf.out_valid), 64'd1);
      checkOutput("t5DIdx",   64'(dutIf.out_idx),   64'd0);
      checkOutput("t5DSeq",   64'(dutIf.out_seq),   64'd10);
      drain("t5Drain", 100);

      // Reset mid-frame with the pending slot occupied.
      step();
      applyStimulus(1'b1, makePack(64'hC000));
      pushFrame(16'd11, 64'hC000);
      step();
      applyStimulus(1'b1, makePack(64'hD000));
      pushFrame(16'd12, 64'hD000);
      step();
      applyStimulus(1'b0, '0);
      waitBeat("t6WaitIdx10", 5'd10, 16'd11, 40);
      rstn = 1'b0;
      #1;
      checkResetOutputs("t6Async");
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      step();
      applyStimulus(1'b1, makePack(64'hE000));
      pushFrame(16'd0, 64'hE000);
      step();
      applyStimulus(1'b0, '0);
      @(negedge clk);
      checkOutput("t6Valid", 64'(dutIf.out_valid), 64'd1);
      checkOutput("t6Seq",   64'(dutIf.out_seq),   64'd0);
      drain("t6Drain", 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_snapshot_streamer.md
# csr_snapshot_streamer

Takes a full `CSRStruct::CSRPack` snapshot on every commit strobe and streams it out as a framed sequence of 64-bit beats over a valid/ready interface. It is the read-out side of the CSR pack and sits between the CSR file / commit stage and the cosim/debug trace sink. It holds one active frame and one pending frame, and drops and counts snapshots when both slots are occupied.

## Interface
Parameters:
- `DROP_W`, 16: width of the saturating drop counter.
- `SEQ_W`, 16: width of the frame sequence number; wraps.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `commit_valid`, in, 1: sample `csr_in` this cycle.
- `csr_in`, in, CSRPack: snapshot to capture.
- `out_valid`, out, 1: beat available.
- `out_ready`, in, 1: sink accepts the beat.
- `out_data`, out, 64: field value.
- `out_idx`, out, 5: field index, 0..28.
- `out_last`, out, 1: high on index 28.
- `out_seq`, out, SEQ_W: frame number of the current beat.
- `busy`, out, 1: an active frame is in flight.
- `drop_cnt`, out, DROP_W: snapshots lost; saturates at all-ones.

## Operation
- Beat order, index 0..28:
  - 0–8: sstatus, sie, stvec, sscratch, sepc, scause, stval, sip, satp.
  - 9–17: mstatus, mie, mtvec, mcounteren, mscratch, mepc, mcause, mtval, mip.
  - 18–21: medeleg, mideleg, mcycle, minstret.
  - 22–28: priv, switch_mode, pc_csr, cosim_epc, cosim_cause, cosim_tval, csr_ret.
- Storage: an active slot and a pending slot, each holding a full CSRPack plus its seq number.
- The seq counter starts at 0 and increments by 1 (mod 2^SEQ_W) on every accepted, non-dropped commit.
- FSM states:
  - IDLE: `out_valid`=0.
    - On `commit_valid`: load the active slot, beat index to 0, go to SEND.
  - SEND: `out_valid`=1.
    - On handshake (`out_valid && out_ready`) with index < 28: index +1.
    - On handshake at index 28, pending full: pending moves to active, index 0, stay in SEND with no bubble.
    - On handshake at index 28, pending empty, `commit_valid`=1: `csr_in` loads active directly, stay in SEND.
    - On handshake at index 28, otherwise: go to IDLE.
- Commit while in SEND:
  - Pending empty: store to pending.
  - Pending full and final handshake in the same cycle: pending moves to active and `csr_in` goes to pending.
  - Pending full and no final handshake: drop the snapshot and increment `drop_cnt` (saturating). Seq does not advance.
- `out_data`, `out_idx`, `out_last`, `out_seq` must stay stable while `out_valid && !out_ready`.
- Beats are muxed from the active slot by index. Outputs are registered or directly decoded from registered state; there is no combinational path from `commit_valid` or `csr_in` to any output.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `out_seq`=0, `busy`=0, `drop_cnt`=0. Both slots are invalid, FSM is IDLE, seq counter is 0.
- Reset asserted mid-frame aborts immediately. The partial frame is not resumed, and the pending slot is discarded.
- Latency: commit in cycle t gives `out_valid`=1 with idx 0 in cycle t+1.
- With `out_ready` held high, a frame takes 29 cycles, and back-to-back frames have zero idle cycles.
- `busy` equals `out_valid`.
- `out_ready` may change in any cycle. A beat completes only on a cycle where `out_valid && out_ready` is sampled at the rising edge.

## Test plan
- Single frame, ready=1:
  - Stimulus: commit one pack, each field = 64'h1000+index, in cycle 5.
  - Required: beats idx 0..28 in cycles 6..34, data 0x1000..0x101C, `out_last` only at idx 28, `out_seq`=0, `out_valid`=0 in cycle 35.
- Backpressure:
  - Stimulus: toggle `out_ready` pseudo-randomly during a frame.
  - Required: every beat appears exactly once, in order, and data/idx stay stable while stalled.
- Pending chain:
  - Stimulus: commit A, then commit B at cycle +3, ready=1.
  - Required: B's idx 0 follows A's idx 28 in the next cycle, with seq 0 then 1.
- Overflow:
  - Stimulus: commit A, B, C, D on consecutive cycles, ready=0.
  - Required: A active, B pending, C and D dropped, `drop_cnt`=2. After release only A and B are streamed (seq 0, 1), and the next commit gets seq 2.
- Simultaneous final handshake and commit:
  - Setup: pending full; commit C in the cycle of A's idx-28 handshake.
  - Required: B goes active, C goes pending, `drop_cnt` unchanged.
  - Also check the case with pending empty: C goes active directly with no bubble.
- Reset mid-frame:
  - Stimulus: deassert `rstn` at idx 10 with pending full.
  - Required: all outputs go to their reset values asynchronously. After release, a new commit streams with seq 0.
